// File: rtl/debug_dump_sequencer_pkg.sv
// Shared debug-unit package: dump FSM encodings, sizing constants, clogb2.
// Reused by the sequencer, the debug unit and the host decoder.
package debug_dump_sequencer_pkg;

   localparam int LONGITUD_INSTRUCCION = 32;
   localparam int CANT_BITS_CONTROL    = 4;
   localparam int CANT_CAMPOS          = 12;
   localparam int WIDTH_BYTE_OUT       = 8;
   localparam int BYTES_POR_PALABRA    =
      LONGITUD_INSTRUCCION / WIDTH_BYTE_OUT;

   // Bits needed to count 0..value-1; never narrower than one bit.
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1)
         r = r + 1;
      if (r == 0)
         r = 1;
      return r;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_LATCH   = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4,
      ST_DONE    = 3'd5
   } dump_state_t;

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Database select/word and UART TX byte handshake of the dump sequencer.
// master = sequencer side, slave = database mux plus UART transmitter.
interface debug_dump_sequencer_if #(
   parameter int W_DATO = 32,
   parameter int W_CTRL = 4,
   parameter int W_BYTE = 8
) ();

   logic [W_DATO-1:0] i_dato;
   logic [W_CTRL-1:0] o_control;
   logic [W_BYTE-1:0] o_tx_data;
   logic              o_tx_start;
   logic              i_tx_done;

   modport master (
      input  i_dato,
      input  i_tx_done,
      output o_control,
      output o_tx_data,
      output o_tx_start
   );

   modport slave (
      output i_dato,
      output i_tx_done,
      input  o_control,
      input  o_tx_data,
      input  o_tx_start
   );

endinterface

// File: rtl/debug_dump_sequencer_word_byte_serializer.sv
// Latches one database word and presents it MSB byte first, one byte
// per shift, flagging the last byte of the word.
module word_byte_serializer
   import debug_dump_sequencer_pkg::*;
#(
   parameter int W_WORD = LONGITUD_INSTRUCCION,
   parameter int W_BYTE = WIDTH_BYTE_OUT
) (
   input  logic              i_clock,
   input  logic              i_soft_reset,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [W_WORD-1:0] i_word,
   output logic [W_BYTE-1:0] o_byte,
   output logic              o_last
);

   localparam int N_BYTES = W_WORD / W_BYTE;
   localparam int BB      = clogb2(N_BYTES);

   logic [W_WORD-1:0] r_word;
   logic [BB-1:0]     r_byte;

   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         r_word <= '0;
         r_byte <= '0;
      end else if (i_load) begin
         r_word <= i_word;
         r_byte <= '0;
      end else if (i_shift) begin
         r_word <= r_word << W_BYTE;
         r_byte <= r_byte + 1'b1;
      end
   end

   assign o_byte = r_word[W_WORD-1 -: W_BYTE];
   assign o_last = (r_byte == BB'(N_BYTES - 1));

endmodule

// File: rtl/debug_dump_sequencer.sv
// Walks every database field, latches each word and streams it
// MSB byte first to the UART TX with a start/done handshake.
module debug_dump_sequencer
   import debug_dump_sequencer_pkg::*;
#(
   parameter int LONGITUD_INSTRUCCION_P = LONGITUD_INSTRUCCION,
   parameter int CANT_BITS_CONTROL_P    = CANT_BITS_CONTROL,
   parameter int CANT_CAMPOS_P          = CANT_CAMPOS,
   parameter int WIDTH_BYTE_OUT_P       = WIDTH_BYTE_OUT
) (
   input  logic i_clock,
   input  logic i_soft_reset,
   input  logic i_start,
   output logic o_busy,
   output logic o_done,
   debug_dump_sequencer_if.master bus
);

   localparam int CB = CANT_BITS_CONTROL_P;

   dump_state_t r_state;
   logic [CB-1:0] r_field;
   logic          r_tx_start;
   logic          r_busy;
   logic          r_done;

   logic                        w_load;
   logic                        w_shift;
   logic                        w_last;
   logic                        w_last_field;
   logic [WIDTH_BYTE_OUT_P-1:0] w_byte;

   assign w_load       = (r_state == ST_LATCH);
   assign w_shift      = (r_state == ST_WAIT_TX) && bus.i_tx_done && !w_last;
   assign w_last_field = (r_field == CB'(CANT_CAMPOS_P - 1));

   word_byte_serializer #(
      .W_WORD (LONGITUD_INSTRUCCION_P),
      .W_BYTE (WIDTH_BYTE_OUT_P)
   ) u_ser (
      .i_clock      (i_clock),
      .i_soft_reset (i_soft_reset),
      .i_load       (w_load),
      .i_shift      (w_shift),
      .i_word       (bus.i_dato),
      .o_byte       (w_byte),
      .o_last       (w_last)
   );

   // Outputs are registered on entry to the state that owns them.
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         r_state    <= ST_IDLE;
         r_field    <= '0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_SELECT;
                  r_field <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SELECT: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_state    <= ST_SEND;
               r_tx_start <= 1'b1;
            end
            ST_SEND: r_state <= ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (bus.i_tx_done) begin
                  if (!w_last) begin
                     r_state    <= ST_SEND;
                     r_tx_start <= 1'b1;
                  end else if (!w_last_field) begin
                     r_state <= ST_SELECT;
                     r_field <= r_field + 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_field <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_control  = r_field;
   assign bus.o_tx_start = r_tx_start;
   assign bus.o_tx_data  = w_byte;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: database model, UART ack
// model and a byte scoreboard filled before each dump.
module tb_debug_dump_sequencer;
   import debug_dump_sequencer_pkg::*;

   typedef struct {
      logic [7:0] d;
      int         f;
      int         b;
   } exp_t;

   logic clk;
   logic rst;
   logic i_start;
   logic o_busy;
   logic o_done;
   logic r_ovr;
   logic r_pat;

   int errors;
   int checks;
   exp_t q[$];

   debug_dump_sequencer_if #(
      .W_DATO (32),
      .W_CTRL (4),
      .W_BYTE (8)
   ) bus ();

   debug_dump_sequencer dut (
      .i_clock      (clk),
      .i_soft_reset (rst),
      .i_start      (i_start),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Database mux model
   assign bus.i_dato = r_ovr ? 32'hFFFF_FFFF :
      (r_pat && bus.o_control == 4'd0) ? 32'hA1B2_C3D4 :
      {28'h0, bus.o_control};

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump(input bit pat);
      logic [31:0] w;
      exp_t e;
      for (int f = 0; f < CANT_CAMPOS; f++) begin
         w = (pat && f == 0) ? 32'hA1B2_C3D4 : 32'(f);
         for (int b = 0; b < BYTES_POR_PALABRA; b++) begin
            e.d = w[31-8*b -: 8];
            e.f = f;
            e.b = b;
            q.push_back(e);
         end
      end
   endtask

   task automatic run_dump(input int d, input bit inject,
                           input int abort_f, input int abort_b,
                           output int starts, output int dones,
                           output bit aborted);
      int cyc;
      int ack_at;
      int lastf;
      int lastb;
      bit stop;
      exp_t e;
      cyc = 0;
      ack_at = -100;
      lastf = -1;
      lastb = -1;
      stop = 0;
      starts = 0;
      dones = 0;
      aborted = 0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      while (!stop && cyc < 3000) begin
         if (bus.o_tx_start) begin
            starts++;
            if (q.size() == 0) begin
               chk("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               chk("tx_byte", 64'(bus.o_tx_data), 64'(e.d));
               chk("tx_field", 64'(bus.o_control), 64'(e.f));
               lastf = e.f;
               lastb = e.b;
               ack_at = cyc + d;
               if (inject && e.f == 2 && e.b == 0)
                  r_ovr = 1'b1;
               if (e.f == abort_f && e.b == abort_b) begin
                  #2 rst = 1'b1;
                  #1;
                  chk("abort_outs",
                      64'({o_busy, o_done, bus.o_tx_start,
                           bus.o_control, bus.o_tx_data}), 64'd0);
                  stop = 1;
                  aborted = 1;
                  q.delete();
               end
            end
         end
         if (!stop && o_done) begin
            dones++;
            chk("busy_at_done", 64'(o_busy), 64'd0);
            stop = 1;
         end
         if (!stop) begin
            bus.i_tx_done = (cyc == ack_at);
            if (inject && lastf == 3 && lastb == 3 && cyc == ack_at + 1)
               bus.i_tx_done = 1'b1;
            i_start = inject && lastf == 1 && lastb == 1 &&
                      cyc == ack_at - d + 1;
            if (inject && lastf == 2 && lastb == 3 && cyc == ack_at)
               r_ovr = 1'b0;
            tick();
            cyc++;
         end
      end
      bus.i_tx_done = 1'b0;
      i_start = 1'b0;
      r_ovr = 1'b0;
      if (!stop)
         chk("dump_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      int starts;
      int dones;
      bit aborted;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      i_start = 1'b0;
      bus.i_tx_done = 1'b0;
      r_ovr = 1'b0;
      r_pat = 1'b0;
      repeat (3) tick();
      chk("reset_outs", 64'({o_busy, o_done, bus.o_tx_start,
                            bus.o_control, bus.o_tx_data}), 64'd0);
      rst = 1'b0;
      tick();

      // Latency and asynchronous reset without a clock edge
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("lat_busy_n1", 64'(o_busy), 64'd1);
      chk("lat_ctrl_n1", 64'(bus.o_control), 64'd0);
      chk("lat_start_n1", 64'(bus.o_tx_start), 64'd0);
      tick();
      chk("lat_start_n2", 64'(bus.o_tx_start), 64'd0);
      tick();
      chk("lat_start_n3", 64'(bus.o_tx_start), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outs", 64'({o_busy, o_done, bus.o_tx_start,
                                bus.o_control, bus.o_tx_data}), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Byte order with slow acks, then the rest of the dump
      r_pat = 1'b1;
      push_dump(1'b1);
      run_dump(5, 1'b0, -1, -1, starts, dones, aborted);
      chk("slow_starts", 64'(starts), 64'd48);
      chk("slow_dones", 64'(dones), 64'd1);
      chk("slow_q_empty", 64'(q.size()), 64'd0);
      tick();
      chk("after_done", 64'({o_done, o_busy, bus.o_control}), 64'd0);
      r_pat = 1'b0;
      repeat (2) tick();

      // Fast acks with ignored inputs and a late database change
      push_dump(1'b0);
      run_dump(1, 1'b1, -1, -1, starts, dones, aborted);
      chk("fast_starts", 64'(starts), 64'd48);
      chk("fast_dones", 64'(dones), 64'd1);
      chk("fast_q_empty", 64'(q.size()), 64'd0);
      repeat (3) tick();
      chk("no_restart", 64'({o_busy, bus.o_tx_start}), 64'd0);

      // Reset in the middle of field 5
      push_dump(1'b0);
      run_dump(1, 1'b0, 5, 2, starts, dones, aborted);
      chk("abort_hit", 64'(aborted), 64'd1);
      chk("abort_no_done", 64'(dones), 64'd0);
      tick();
      chk("abort_idle", 64'({o_done, o_busy}), 64'd0);
      rst = 1'b0;
      tick();

      // Restart after the aborted dump
      push_dump(1'b0);
      run_dump(2, 1'b0, -1, -1, starts, dones, aborted);
      chk("restart_starts", 64'(starts), 64'd48);
      chk("restart_dones", 64'(dones), 64'd1);
      chk("restart_q_empty", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
